// File: rtl/pipe_issue.sv
// Operand-pair issue FIFO driving the x/y register of a fixed-latency pipe, with result tracking.
// Define PIPE_ISSUE_ZERO_FLAG_EN to build the zero-operand marker and its delay line.
module pipe_issue #(
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:31]              in_x,
    input  logic [0:31]              in_y,
    output logic [0:31]              x,
    output logic [0:31]              y,
    output logic                     out_valid,
    output logic                     res_valid,
    output logic [15:0]              res_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     zero_flag
);
    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;

    logic [0:DATA_W-1] mem_x [DEPTH];
    logic [0:DATA_W-1] mem_y [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     lvl;
    logic              push;
    logic              pop;

    logic [0:DATA_W-1] x_p0;
    logic [0:DATA_W-1] y_p0;
    logic              vld_p0;
    logic [LAT-1:0]    vld_p1;
    logic [15:0]       res_cnt;

    assign in_ready = (lvl < LW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (lvl != '0);

    // FIFO control: pop is unconditional whenever anything is queued
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_x[wr_ptr] <= in_x;
            mem_y[wr_ptr] <= in_y;
        end
    end

    // Stage p0: x/y operand register; an empty FIFO issues a zero bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            x_p0   <= '0;
            y_p0   <= '0;
            vld_p0 <= 1'b0;
        end else if (pop) begin
            x_p0   <= mem_x[rd_ptr];
            y_p0   <= mem_y[rd_ptr];
            vld_p0 <= 1'b1;
        end else begin
            x_p0   <= '0;
            y_p0   <= '0;
            vld_p0 <= 1'b0;
        end
    end

    // Stage p1: LAT-deep valid delay matching the downstream pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= '0;
        end else begin
            vld_p1[0] <= vld_p0;
            for (int i = 1; i < LAT; i++) begin
                vld_p1[i] <= vld_p1[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt <= '0;
        end else if (vld_p1[LAT-1]) begin
            res_cnt <= res_cnt + 16'd1;
        end
    end

`ifdef PIPE_ISSUE_ZERO_FLAG_EN
    logic           zmark_p0;
    logic [LAT-1:0] zmark_p1;

    // Sign bit is ignored so that -0.0 is marked as well
    assign zmark_p0 = (x_p0[1:DATA_W-1] == '0) | (y_p0[1:DATA_W-1] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            zmark_p1 <= '0;
        end else begin
            zmark_p1[0] <= zmark_p0;
            for (int i = 1; i < LAT; i++) begin
                zmark_p1[i] <= zmark_p1[i-1];
            end
        end
    end

    assign zero_flag = vld_p1[LAT-1] & zmark_p1[LAT-1];
`else
    assign zero_flag = 1'b0;
`endif

    assign x         = x_p0;
    assign y         = y_p0;
    assign out_valid = vld_p0;
    assign res_valid = vld_p1[LAT-1];
    assign res_count = res_cnt;
    assign level     = lvl;

endmodule

// File: tb/tb_pipe_issue.sv
// Scoreboard bench for pipe_issue: directed operand pairs, monitor checks order, latency and flags.
module tb_pipe_issue;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
`ifdef PIPE_ISSUE_ZERO_FLAG_EN
    localparam bit ZF_EN = 1'b1;
`else
    localparam bit ZF_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [0:31]            in_x;
    logic [0:31]            in_y;
    logic [0:31]            x;
    logic [0:31]            y;
    logic                   out_valid;
    logic                   res_valid;
    logic [15:0]            res_count;
    logic [$clog2(DEPTH):0] level;
    logic                   zero_flag;

    pipe_issue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .res_valid (res_valid),
        .res_count (res_count),
        .level     (level),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        zf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic zf;
        int   cyc;
    } rexp_t;

    exp_t  exp_q[$];
    rexp_t res_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_res  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pairs leaving x/y are matched against the scoreboard, then results against x/y issue
    always @(negedge clk) begin : mon
        exp_t  e;
        rexp_t r;
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_unexpected: got x=0x%08h y=0x%08h, required no pair", x, y);
                end else begin
                    e = exp_q.pop_front();
                    check("x_order", x, e.x);
                    check("y_order", y, e.y);
                    check("out_latency", 32'(cyc), 32'(e.cyc + 1));
                    res_q.push_back('{e.zf, cyc + LAT});
                end
            end else begin
                check("x_idle", x, 32'd0);
                check("y_idle", y, 32'd0);
            end
            if (res_valid) begin
                n_res++;
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL res_unexpected: got res_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    r = res_q.pop_front();
                    check("res_latency", 32'(cyc), 32'(r.cyc));
                    check("zero_flag", 32'(zero_flag), 32'(r.zf));
                end
            end else begin
                check("zero_flag_idle", 32'(zero_flag), 32'd0);
            end
        end
    end

    task automatic drive_pair(input logic [31:0] vx, input logic [31:0] vy, input logic zf);
        in_valid = 1'b1;
        in_x     = vx;
        in_y     = vy;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back('{vx, vy, (ZF_EN ? zf : 1'b0), cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] vec_x  [5] = '{32'h00000000, 32'hC1900000, 32'h45129200, 32'h3F800000, 32'hBF800000};
    logic [31:0] vec_y  [5] = '{32'h41180000, 32'h41180000, 32'h3F400000, 32'h3F800000, 32'h3F800000};
    logic        vec_zf [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int base;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_x", x, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_zero_flag", 32'(zero_flag), 32'd0);
        @(posedge clk);
        #1;

        // single pair
        drive_pair(32'h3F800000, 32'h3F800000, 1'b0);
        idle(LAT + 3);
        @(negedge clk);
        check("single_res_count", 32'(res_count), 32'd1);
        check("single_res_pulses", 32'(n_res), 32'd1);
        @(posedge clk);
        #1;

        // back-to-back stream of five pairs
        base = n_res;
        for (int i = 0; i < 5; i++) drive_pair(vec_x[i], vec_y[i], vec_zf[i]);
        idle(LAT + 4);
        @(negedge clk);
        check("stream_res_pulses", 32'(n_res - base), 32'd5);
        check("stream_level", 32'(level), 32'd0);
        check("stream_res_count", 32'(res_count), 32'd6);
        @(posedge clk);
        #1;

        // zero-flag pairs, including -0.0 in y
        base = n_res;
        drive_pair(32'h00000000, 32'h41180000, 1'b1);
        drive_pair(32'h3F800000, 32'h3F800000, 1'b0);
        drive_pair(32'h3F800000, 32'h80000000, 1'b1);
        idle(LAT + 4);
        @(negedge clk);
        check("zf_res_pulses", 32'(n_res - base), 32'd3);
        @(posedge clk);
        #1;

        // res_count wrap
        @(negedge clk);
        force dut.res_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.res_cnt;
        @(negedge clk);
        check("wrap_preload", 32'(res_count), 32'h0000FFFF);
        @(posedge clk);
        #1;
        drive_pair(32'h3F800000, 32'h3F800000, 1'b0);
        idle(LAT + 3);
        @(negedge clk);
        check("wrap_res_count", 32'(res_count), 32'd0);
        @(posedge clk);
        #1;

        // reset mid-stream discards queued and in-flight pairs
        for (int i = 0; i < 4; i++) drive_pair(vec_x[i], vec_y[i], vec_zf[i]);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        res_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = n_res;
        @(negedge clk);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_res_count", 32'(res_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        idle(LAT + 4);
        @(negedge clk);
        check("midrst_no_res", 32'(n_res - base), 32'd0);
        check("midrst_res_count_hold", 32'(res_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
